// File: rtl/trap_seq_pkg.sv
// ============================================================================
// Module   : trap_seq_pkg
// Brief    : Shared CSR addresses, CSR-port function codes, mstatus bit
//            positions, interrupt cause codes and the trap sequencer states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package trap_seq_pkg;

    // Machine-mode CSR addresses touched by the sequencer
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // CSR write-port function codes (0 means no operation)
    localparam logic [1:0] CSR_RW = 2'b01;
    localparam logic [1:0] CSR_RS = 2'b10;
    localparam logic [1:0] CSR_RC = 2'b11;

    // mstatus bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // Interrupt cause codes (low bits of mcause for interrupts)
    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;
    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;

    // Sequencer states, explicitly encoded
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_W_EPC      = 4'd1,
        ST_W_CAUSE    = 4'd2,
        ST_W_TVAL     = 4'd3,
        ST_W_STAT_CLR = 4'd4,
        ST_W_STAT_SET = 4'd5,
        ST_M_CLR      = 4'd6,
        ST_M_SET      = 4'd7,
        ST_REDIRECT   = 4'd8
    } state_e;

    // Single-bit mstatus mask for the given bit position
    function automatic logic [7:0] mstatus_bit(input int pos);
        logic [7:0] m;
        m      = '0;
        m[pos] = 1'b1;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trap_seq_irq_pick.sv
// ============================================================================
// Module   : irq_pick
// Brief    : Machine interrupt qualifier and priority encoder.
//            Priority is external > software > timer; nothing is pending
//            while the global interrupt enable is clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_pick
    import trap_seq_pkg::*;
(
    input  logic       i_meip,
    input  logic       i_msip,
    input  logic       i_mtip,
    input  logic       i_mie_meie,
    input  logic       i_mie_msie,
    input  logic       i_mie_mtie,
    input  logic       i_glb_mie,
    output logic       o_pending,
    output logic [3:0] o_code
);

    logic w_mei;
    logic w_msi;
    logic w_mti;

    assign w_mei = i_glb_mie & i_meip & i_mie_meie;
    assign w_msi = i_glb_mie & i_msip & i_mie_msie;
    assign w_mti = i_glb_mie & i_mtip & i_mie_mtie;

    // Fixed-priority selection of the highest pending enabled interrupt
    always_comb begin
        o_pending = 1'b0;
        o_code    = 4'd0;
        if (w_mei) begin
            o_pending = 1'b1;
            o_code    = IRQ_CODE_MEI;
        end else if (w_msi) begin
            o_pending = 1'b1;
            o_code    = IRQ_CODE_MSI;
        end else if (w_mti) begin
            o_pending = 1'b1;
            o_code    = IRQ_CODE_MTI;
        end
    end

endmodule

`default_nettype wire

// File: rtl/trap_seq.sv
// ============================================================================
// Module   : trap_seq
// Brief    : Machine-mode trap / MRET sequencer. Accepts an exception,
//            interrupt or MRET in IDLE, walks the CSR updates one per cycle
//            through the CSR write port, then issues a one-cycle fetch
//            redirect. Outputs decode from the state register so an
//            asynchronous reset silences them immediately.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_seq
    import trap_seq_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic            meip,
    input  logic            msip,
    input  logic            mtip,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] mie,
    input  logic            mstatus_mie,
    input  logic            mstatus_mpie,
    output logic [11:0]     csraddr,
    output logic [1:0]      funct,
    output logic [XLEN-1:0] wdata,
    output logic            wen,
    output logic            busy,
    output logic            req_ack,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [7:0] C_STAT_CLR_MASK = mstatus_bit(MSTATUS_MIE) | mstatus_bit(MSTATUS_MPIE);
    localparam logic [7:0] C_STAT_MPIE     = mstatus_bit(MSTATUS_MPIE);
    localparam logic [7:0] C_STAT_MIE      = mstatus_bit(MSTATUS_MIE);

    state_e          r_state;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_tval;
    logic            r_mie_lat;
    logic            r_mpie_lat;
    logic            r_is_irq;
    logic            r_is_mret;

    logic            w_irq_pending;
    logic [3:0]      w_irq_code;
    logic [XLEN-1:0] w_irq_cause;
    logic            w_accept;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_vec_tgt;
    logic            w_unused_mie;

    irq_pick u_irq_pick (
        .i_meip     (meip),
        .i_msip     (msip),
        .i_mtip     (mtip),
        .i_mie_meie (mie[11]),
        .i_mie_msie (mie[3]),
        .i_mie_mtie (mie[7]),
        .i_glb_mie  (mstatus_mie),
        .o_pending  (w_irq_pending),
        .o_code     (w_irq_code)
    );

    // Only the three machine interrupt enables of mie matter here
    assign w_unused_mie = ^mie;

    assign w_irq_cause = {1'b1, {(XLEN-5){1'b0}}, w_irq_code};

    // Requests are only looked at in IDLE; reset masks the acknowledge at once
    assign w_accept = rst_n & (r_state == ST_IDLE) & (exc_valid | w_irq_pending | mret_valid);
    assign req_ack  = w_accept;
    assign busy     = (r_state != ST_IDLE);

    // Trap vector: direct base, or base + 4*cause for vectored interrupts
    assign w_base    = {mtvec[XLEN-1:2], 2'b00};
    assign w_vec_tgt = w_base + XLEN'({r_cause[3:0], 2'b00});

    // Sequencer state and request context captured at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cause    <= '0;
            r_pc       <= '0;
            r_tval     <= '0;
            r_mie_lat  <= 1'b0;
            r_mpie_lat <= 1'b0;
            r_is_irq   <= 1'b0;
            r_is_mret  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (exc_valid) begin
                        r_cause   <= XLEN'(exc_cause);
                        r_pc      <= exc_pc;
                        r_tval    <= exc_tval;
                        r_mie_lat <= mstatus_mie;
                        r_is_irq  <= 1'b0;
                        r_is_mret <= 1'b0;
                        r_state   <= ST_W_EPC;
                    end else if (w_irq_pending) begin
                        r_cause   <= w_irq_cause;
                        r_pc      <= exc_pc;
                        r_tval    <= '0;
                        r_mie_lat <= mstatus_mie;
                        r_is_irq  <= 1'b1;
                        r_is_mret <= 1'b0;
                        r_state   <= ST_W_EPC;
                    end else if (mret_valid) begin
                        r_mpie_lat <= mstatus_mpie;
                        r_is_irq   <= 1'b0;
                        r_is_mret  <= 1'b1;
                        r_state    <= ST_M_CLR;
                    end
                end
                ST_W_EPC:      r_state <= ST_W_CAUSE;
                ST_W_CAUSE:    r_state <= ST_W_TVAL;
                ST_W_TVAL:     r_state <= ST_W_STAT_CLR;
                ST_W_STAT_CLR: r_state <= ST_W_STAT_SET;
                ST_W_STAT_SET: r_state <= ST_REDIRECT;
                ST_M_CLR:      r_state <= ST_M_SET;
                ST_M_SET:      r_state <= ST_REDIRECT;
                ST_REDIRECT:   r_state <= ST_IDLE;
                default:       r_state <= ST_IDLE;
            endcase
        end
    end

    // CSR write port and redirect decoded from the current state
    always_comb begin
        csraddr        = 12'd0;
        funct          = 2'b00;
        wdata          = '0;
        wen            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (r_state)
            ST_W_EPC: begin
                csraddr = CSR_MEPC;
                funct   = CSR_RW;
                wdata   = r_pc;
                wen     = 1'b1;
            end
            ST_W_CAUSE: begin
                csraddr = CSR_MCAUSE;
                funct   = CSR_RW;
                wdata   = r_cause;
                wen     = 1'b1;
            end
            ST_W_TVAL: begin
                csraddr = CSR_MTVAL;
                funct   = CSR_RW;
                wdata   = r_tval;
                wen     = 1'b1;
            end
            ST_W_STAT_CLR, ST_M_CLR: begin
                csraddr = CSR_MSTATUS;
                funct   = CSR_RC;
                wdata   = XLEN'(C_STAT_CLR_MASK);
                wen     = 1'b1;
            end
            ST_W_STAT_SET: begin
                // MPIE takes the interrupt enable seen at accept
                csraddr = CSR_MSTATUS;
                funct   = CSR_RS;
                wdata   = XLEN'(C_STAT_MPIE);
                wen     = r_mie_lat;
            end
            ST_M_SET: begin
                // MIE is restored from MPIE seen at accept
                csraddr = CSR_MSTATUS;
                funct   = CSR_RS;
                wdata   = XLEN'(C_STAT_MIE);
                wen     = r_mpie_lat;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                if (r_is_mret) begin
                    redirect_pc = mepc;
                end else if ((mtvec[1:0] == 2'b01) && r_is_irq) begin
                    redirect_pc = w_vec_tgt;
                end else begin
                    redirect_pc = w_base;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_trap_seq.sv
// ============================================================================
// Module   : tb_trap_seq
// Brief    : Self-checking bench for trap_seq. Stimulus pushes the expected
//            CSR writes and redirect (with latency from accept) into a
//            scoreboard queue; a monitor pops and compares each DUT event.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_seq;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            exc_valid;
    logic [3:0]      exc_cause;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] exc_tval;
    logic            mret_valid;
    logic            meip;
    logic            msip;
    logic            mtip;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mie;
    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic [11:0]     csraddr;
    logic [1:0]      funct;
    logic [XLEN-1:0] wdata;
    logic            wen;
    logic            busy;
    logic            req_ack;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    trap_seq #(.XLEN(XLEN)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .mret_valid     (mret_valid),
        .meip           (meip),
        .msip           (msip),
        .mtip           (mtip),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .mie            (mie),
        .mstatus_mie    (mstatus_mie),
        .mstatus_mpie   (mstatus_mpie),
        .csraddr        (csraddr),
        .funct          (funct),
        .wdata          (wdata),
        .wen            (wen),
        .busy           (busy),
        .req_ack        (req_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct packed {
        logic        redir;
        logic [11:0] addr;
        logic [1:0]  fn;
        logic [63:0] data;
        logic [7:0]  ofs;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   ack_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_w(input logic [11:0] a, input logic [1:0] f, input logic [63:0] d, input int o);
        sb.push_back('{redir: 1'b0, addr: a, fn: f, data: d, ofs: 8'(o)});
    endtask

    task automatic push_r(input logic [63:0] pc, input int o);
        sb.push_back('{redir: 1'b1, addr: 12'd0, fn: 2'b00, data: pc, ofs: 8'(o)});
    endtask

    // Full trap path as the CSR file should see it, plus the redirect
    task automatic push_trap(input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] tval,
                             input logic mie_lat, input logic [63:0] tgt);
        push_w(12'h341, 2'b01, pc, 1);
        push_w(12'h342, 2'b01, cause, 2);
        push_w(12'h343, 2'b01, tval, 3);
        push_w(12'h300, 2'b11, 64'h88, 4);
        if (mie_lat) push_w(12'h300, 2'b10, 64'h80, 5);
        push_r(tgt, 6);
    endtask

    task automatic push_mret(input logic mpie_lat, input logic [63:0] tgt);
        push_w(12'h300, 2'b11, 64'h88, 1);
        if (mpie_lat) push_w(12'h300, 2'b10, 64'h08, 2);
        push_r(tgt, 3);
    endtask

    task automatic wait_ack(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ack) begin
                at = cyc;
                break;
            end
        end
        chk({tag, "_ack_seen"}, 64'(at >= 0), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic drive_exc(input logic [3:0] c, input logic [63:0] pc, input logic [63:0] tv);
        @(posedge clk);
        #1;
        exc_cause = c;
        exc_pc    = pc;
        exc_tval  = tv;
        exc_valid = 1'b1;
    endtask

    // Monitor: every write/redirect pops the next expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_ack) ack_cyc = cyc;
                if (wen || redirect_valid) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_event", {62'd0, wen, redirect_valid}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("busy_during_seq", 64'(busy), 64'd1);
                        if (e.redir) begin
                            chk("redir_valid", 64'(redirect_valid), 64'd1);
                            chk("redir_pc", redirect_pc, e.data);
                        end else begin
                            chk("wr_en", 64'(wen), 64'd1);
                            chk("wr_addr", 64'(csraddr), 64'(e.addr));
                            chk("wr_funct", 64'(funct), 64'(e.fn));
                            chk("wr_data", wdata, e.data);
                        end
                        chk("latency", 64'(cyc - ack_cyc), 64'(e.ofs));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  a1;
        int  a2;
        bit  seen;

        rst_n = 1'b0; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
        mret_valid = 1'b0; meip = 1'b0; msip = 1'b0; mtip = 1'b0;
        mtvec = '0; mepc = '0; mie = '0; mstatus_mie = 1'b0; mstatus_mpie = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wen", 64'(wen), 64'd0);
        chk("rst_ack", 64'(req_ack), 64'd0);
        chk("rst_redir", 64'(redirect_valid), 64'd0);
        chk("rst_redir_pc", redirect_pc, 64'd0);
        chk("rst_port", {csraddr, funct, 50'd0}, 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        rst_n = 1'b1;

        // Exception, direct vector
        mtvec = 64'h8000_0000; mstatus_mie = 1'b1;
        push_trap(64'h1000, 64'd2, 64'hDEAD, 1'b1, 64'h8000_0000);
        drive_exc(4'd2, 64'h1000, 64'hDEAD);
        wait_ack("exc", a1);
        @(posedge clk); #1 exc_valid = 1'b0;
        wait_drain("exc");

        // Timer interrupt, vectored mtvec
        mtvec = 64'h8000_0001; mie = 64'h80; exc_pc = 64'h3000;
        push_trap(64'h3000, 64'h8000_0000_0000_0007, 64'd0, 1'b1, 64'h8000_001C);
        @(posedge clk); #1 mtip = 1'b1;
        wait_ack("mti", a1);
        @(posedge clk); #1 mtip = 1'b0;
        wait_drain("mti");

        // External interrupt masked by mstatus.mie, then unmasked
        mtvec = 64'h8000_0000; mie = 64'h800; mstatus_mie = 1'b0; exc_pc = 64'h6000;
        @(posedge clk); #1 meip = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (req_ack || busy) seen = 1'b1;
        end
        chk("mei_masked_no_accept", 64'(seen), 64'd0);
        push_trap(64'h6000, 64'h8000_0000_0000_000B, 64'd0, 1'b1, 64'h8000_0000);
        @(posedge clk); #1 mstatus_mie = 1'b1;
        wait_ack("mei", a1);
        @(posedge clk); #1 meip = 1'b0;
        wait_drain("mei");

        // Exception with interrupts disabled: no MPIE set write; vectored
        // mtvec still targets the base for exceptions
        mstatus_mie = 1'b0; mtvec = 64'h8000_0001; mie = '0;
        push_trap(64'h7000, 64'd13, 64'h77, 1'b0, 64'h8000_0000);
        drive_exc(4'd13, 64'h7000, 64'h77);
        wait_ack("exc_nomie", a1);
        @(posedge clk); #1 exc_valid = 1'b0;
        wait_drain("exc_nomie");

        // MRET with MPIE set
        mepc = 64'h2000; mstatus_mpie = 1'b1;
        push_mret(1'b1, 64'h2000);
        @(posedge clk); #1 mret_valid = 1'b1;
        wait_ack("mret", a1);
        @(posedge clk); #1 mret_valid = 1'b0;
        wait_drain("mret");

        // Exception and MRET together; second exception held during busy
        mtvec = 64'h8000_0100; mstatus_mie = 1'b1;
        push_trap(64'h4000, 64'd5, 64'h44, 1'b1, 64'h8000_0100);
        push_trap(64'h5000, 64'd7, 64'h55, 1'b1, 64'h8000_0100);
        @(posedge clk); #1;
        exc_cause = 4'd5; exc_pc = 64'h4000; exc_tval = 64'h44;
        exc_valid = 1'b1; mret_valid = 1'b1;
        wait_ack("both", a1);
        @(posedge clk); #1;
        mret_valid = 1'b0; exc_cause = 4'd7; exc_pc = 64'h5000; exc_tval = 64'h55;
        wait_ack("held_exc", a2);
        chk("held_exc_ack_gap", 64'(a2 - a1), 64'd7);
        @(posedge clk); #1 exc_valid = 1'b0;
        wait_drain("both");

        // Reset in W_CAUSE: abandon sequence, nothing further
        mtvec = 64'h8000_0000;
        push_w(12'h341, 2'b01, 64'h9000, 1);
        drive_exc(4'd4, 64'h9000, 64'h99);
        wait_ack("rstmid", a1);
        @(posedge clk); #1 exc_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("rstmid_wen", 64'(wen), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_port", {csraddr, funct, 50'd0}, 64'd0);
        chk("rstmid_wdata", wdata, 64'd0);
        chk("rstmid_redir", 64'(redirect_valid), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy || wen || redirect_valid) seen = 1'b1;
        end
        chk("rstmid_no_resume", 64'(seen), 64'd0);
        chk("rstmid_sb_empty", 64'(sb.size()), 64'd0);

        // Recovery: MRET with MPIE clear
        mepc = 64'h2468; mstatus_mpie = 1'b0;
        push_mret(1'b0, 64'h2468);
        @(posedge clk); #1 mret_valid = 1'b1;
        wait_ack("mret_nompie", a1);
        @(posedge clk); #1 mret_valid = 1'b0;
        wait_drain("mret_nompie");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
